// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// Receives PS/2 keyboard frames and hands make codes to the processor's
// memory-mapped keyboard port using a toggle handshake.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data   raw PS/2 data from the keyboard (asynchronous)
//   key_reg    last delivered make code, held until the next delivery
//   sample     toggles once per delivered make code
//   frame_err  one-cycle pulse on a parity or stop-bit error
//
// Break sequences (F0 xx) and extended prefixes (E0) are filtered here, so
// each key press yields exactly one toggle of sample.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_reg,
  output logic       sample,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_meta, clk_sync;
  logic          data_meta, data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic          brk;
  logic [WW-1:0] wd_cnt;

  // Two-flop synchronisers; both lines idle high on the PS/2 bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // The filtered clock follows the synchronised clock only once it has
  // disagreed for FILTER_LEN consecutive cycles; any return to agreement
  // restarts the count, which swallows short glitches. fall is registered
  // so the FSM sees a clean one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
        fall     <= ~clk_sync;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame receiver, byte filter and watchdog. A fall always takes priority
  // over the watchdog so a bit arriving exactly at the limit is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      brk        <= 1'b0;
      wd_cnt     <= '0;
      key_reg    <= 8'h00;
      sample     <= 1'b1;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall) begin
        wd_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_sync;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if ((^{shift, parity_bit}) && data_sync) begin
              if (shift == 8'hF0) begin
                brk <= 1'b1;
              end else if (shift != 8'hE0) begin
                if (brk) begin
                  brk <= 1'b0;
                end else begin
                  key_reg <= shift;
                  sample  <= ~sample;
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (wd_cnt == WW'(TIMEOUT)) begin
          state  <= IDLE;
          wd_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule
